// File: rtl/data_rd_pkg.sv
// Shared types and constants for the SD-card frame read controller.
// Also hosts the edge-detector mode type so the write side can reuse edge_det.
package data_rd_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_H,
    WAIT_L,
    NEXT
  } rd_state_e;

  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_ANY
  } edge_mode_e;

  // Counter width for n states, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_rd_ctrl_if.sv
// Bus bundle between data_rd_ctrl, the SD read module and the frame consumer.
// master = the controller; slave = the environment around it.
interface data_rd_ctrl_if
  import data_rd_pkg::*;
#(
  parameter int unsigned FI_W = 3
) ();

  logic              init_end;
  logic              frame;
  logic              rd_busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              frame_done;
  logic [FI_W-1:0]   frame_idx;
  logic              rd_err;

  modport master (
    input  init_end, frame, rd_busy,
    output rd_en, rd_addr, frame_done, frame_idx, rd_err
  );

  modport slave (
    output init_end, frame, rd_busy,
    input  rd_en, rd_addr, frame_done, frame_idx, rd_err
  );

endinterface

// File: rtl/data_rd_ctrl_edge_det.sv
// Registered single-signal edge detector; the edge output is combinational
// from the input and its one-cycle delayed copy.
module edge_det
  import data_rd_pkg::*;
#(
  parameter edge_mode_e MODE = EDGE_RISE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge_c
);

  logic r_d1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d1 <= 1'b0;
    end else begin
      r_d1 <= i_sig;
    end
  end

  always_comb begin
    o_edge_c = 1'b0;
    case (MODE)
      EDGE_RISE: o_edge_c = i_sig & ~r_d1;
      EDGE_FALL: o_edge_c = ~i_sig & r_d1;
      default:   o_edge_c = i_sig ^ r_d1;
    endcase
  end

endmodule

// File: rtl/data_rd_ctrl.sv
// Frame read controller: issues one single-sector read per sector of a frame,
// walking a ring of frame slots. Optional command timeout/retry: RD_TIMEOUT_EN.
module data_rd_ctrl
  import data_rd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'd1000,
  parameter int unsigned       SECT_PER_FRAME = 4,
  parameter int unsigned       FRAME_NUM      = 8
`ifdef RD_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYC    = 1000
`endif
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  data_rd_ctrl_if.master bus
);

  localparam int unsigned     SC_W      = clog2_min1(SECT_PER_FRAME);
  localparam int unsigned     FI_W      = clog2_min1(FRAME_NUM);
  localparam logic [SC_W-1:0] SECT_LAST = SC_W'(SECT_PER_FRAME - 1);
  localparam logic [FI_W-1:0] IDX_LAST  = FI_W'(FRAME_NUM - 1);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [SC_W-1:0]   r_sect_cnt;
  logic [SC_W-1:0]   w_sect_nxt;
  logic [FI_W-1:0]   r_frame_idx;
  logic [FI_W-1:0]   w_idx_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic              r_rd_en;
  logic              r_frame_done;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_req_c;
  logic              w_busy_fall_c;
  logic              w_timeout_c;

  edge_det #(.MODE(EDGE_RISE)) u_frame_edge (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_sig    (bus.frame),
    .o_edge_c (w_req_c)
  );

  edge_det #(.MODE(EDGE_FALL)) u_busy_edge (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_sig    (bus.rd_busy),
    .o_edge_c (w_busy_fall_c)
  );

`ifdef RD_TIMEOUT_EN
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_rd_err;

  // Counts cycles since the last rd_en while waiting for busy
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_to_cnt <= '0;
      r_rd_err <= 1'b0;
    end else begin
      if (r_state == REQ) begin
        r_to_cnt <= TO_W'(1);
      end else if (r_state == WAIT_H) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      r_rd_err <= r_rd_err | w_timeout_c;
    end
  end

  assign w_timeout_c = (r_state == WAIT_H) && !bus.rd_busy && (r_to_cnt == TO_LAST);
  assign bus.rd_err  = r_rd_err;
`else
  assign w_timeout_c = 1'b0;
  assign bus.rd_err  = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sect_nxt  = r_sect_cnt;
    w_idx_nxt   = r_frame_idx;
    w_pend_nxt  = r_pend | w_req_c;
    case (r_state)
      IDLE: begin
        if ((w_req_c | r_pend) & bus.init_end & ~bus.rd_busy) begin
          w_state_nxt = REQ;
          w_pend_nxt  = 1'b0;
        end
      end
      REQ: begin
        w_state_nxt = WAIT_H;
      end
      WAIT_H: begin
        // Level test: busy already high on entry counts as the rise
        if (w_timeout_c) begin
          w_state_nxt = REQ;
        end else if (bus.rd_busy) begin
          w_state_nxt = WAIT_L;
        end
      end
      WAIT_L: begin
        if (w_busy_fall_c) begin
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (r_sect_cnt == SECT_LAST) begin
          w_sect_nxt  = '0;
          w_idx_nxt   = (r_frame_idx == IDX_LAST) ? '0 : r_frame_idx + FI_W'(1);
          w_state_nxt = IDLE;
        end else begin
          w_sect_nxt  = r_sect_cnt + SC_W'(1);
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_addr_nxt = BASE_ADDR
                    + (ADDR_W'(w_idx_nxt) * ADDR_W'(SECT_PER_FRAME))
                    + ADDR_W'(w_sect_nxt);

  // Datapath and registered outputs; address latched only when a command is issued
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sect_cnt   <= '0;
      r_frame_idx  <= '0;
      r_pend       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= BASE_ADDR;
      r_frame_done <= 1'b0;
    end else begin
      r_sect_cnt   <= w_sect_nxt;
      r_frame_idx  <= w_idx_nxt;
      r_pend       <= w_pend_nxt;
      r_rd_en      <= (w_state_nxt == REQ);
      r_frame_done <= (w_state_nxt == NEXT) && (r_sect_cnt == SECT_LAST);
      if (w_state_nxt == REQ) begin
        r_rd_addr <= w_addr_nxt;
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_idx  = r_frame_idx;

endmodule

// File: tb/tb_data_rd_ctrl.sv
// Directed bench for data_rd_ctrl with a behavioural SD read module model
// (busy rises 3 cycles after rd_en and stays high 10 cycles).
module tb_data_rd_ctrl;
  import data_rd_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_busy = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ign_cnt  = 0;
  int m_dly    = 0;
  int m_hold   = 0;

  logic [31:0] q_addr[$];
  logic [2:0]  q_idx[$];
  int          q_cyc[$];

  data_rd_ctrl_if #(.FI_W(3)) bus ();

  data_rd_ctrl #(
    .BASE_ADDR      (32'd1000),
    .SECT_PER_FRAME (4),
    .FRAME_NUM      (8)
`ifdef RD_TIMEOUT_EN
    ,
    .TIMEOUT_CYC    (20)
`endif
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  assign bus.rd_busy = m_busy;

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // SD read module model
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_dly  = 0;
      m_hold = 0;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_busy = 1'b0;
      end else if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin
          m_busy = 1'b1;
          m_hold = 10;
        end
      end
      if (bus.rd_en === 1'b1) begin
        if (ign_cnt > 0) ign_cnt--;
        else m_dly = 3;
      end
    end
  end

  // Command / completion log
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en === 1'b1) begin
        q_addr.push_back(bus.rd_addr);
        q_idx.push_back(bus.frame_idx);
        q_cyc.push_back(cyc);
      end
      if (bus.frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_log();
    q_addr.delete();
    q_idx.delete();
    q_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.frame = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.frame = 1'b1;
    repeat (2) @(negedge clk);
    bus.frame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (q_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame = 1'b0;
    bus.init_end = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rd_en !== 1'b0) begin
      failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.rd_en);
    end
    checks++;
    if (bus.rd_addr !== 32'd1000) begin
      failures++; $display("FAIL reset_rd_addr got=%0d exp=1000", bus.rd_addr);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done);
    end
    checks++;
    if (bus.frame_idx !== 3'd0) begin
      failures++; $display("FAIL reset_frame_idx got=%0d exp=0", bus.frame_idx);
    end
    checks++;
    if (bus.rd_err !== 1'b0) begin
      failures++; $display("FAIL reset_rd_err got=%b exp=0", bus.rd_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [31:0] exp_a;
    apply_reset();
    pulse_frame();
    wait_done(1, 400, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_done_timeout got=%0d exp=1", done_cnt);
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 4) begin
      failures++; $display("FAIL single_cmd_count got=%0d exp=4", q_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'd1000 + 32'(i);
      checks++;
      if (q_addr.size() <= i || q_addr[i] !== exp_a) begin
        failures++; $display("FAIL single_addr%0d got=%0d exp=%0d", i,
                             (q_addr.size() > i) ? q_addr[i] : 32'hFFFF_FFFF, exp_a);
      end
    end
    checks++;
    if (q_idx.size() < 4 || q_idx[3] !== 3'd0) begin
      failures++; $display("FAIL single_idx_during got=%0d exp=0", (q_idx.size() > 3) ? q_idx[3] : 3'd7);
    end
    checks++;
    if (q_cyc.size() < 2 || (q_cyc[1] - q_cyc[0]) != 15) begin
      failures++; $display("FAIL single_spacing got=%0d exp=15", (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt);
    end
    checks++;
    if (bus.frame_idx !== 3'd1) begin
      failures++; $display("FAIL single_frame_idx got=%0d exp=1", bus.frame_idx);
    end
    checks++;
    if (bus.rd_err !== 1'b0) begin
      failures++; $display("FAIL single_rd_err got=%b exp=0", bus.rd_err);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_a;
    logic [2:0]  exp_i;
    apply_reset();
    for (int f = 0; f < 9; f++) begin
      clear_log();
      pulse_frame();
      wait_done(1, 400, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL wrap%0d_done_timeout got=%0d exp=1", f, done_cnt);
      end
      repeat (2) @(negedge clk);
      #1;
      exp_a = 32'd1000 + 32'((f % 8) * 4);
      exp_i = 3'((f + 1) % 8);
      checks++;
      if (q_addr.size() != 4 || q_addr[0] !== exp_a || q_addr[3] !== exp_a + 32'd3) begin
        failures++; $display("FAIL wrap%0d_addr got=%0d exp=%0d n=%0d", f,
                             (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF, exp_a, q_addr.size());
      end
      checks++;
      if (bus.frame_idx !== exp_i) begin
        failures++; $display("FAIL wrap%0d_frame_idx got=%0d exp=%0d", f, bus.frame_idx, exp_i);
      end
    end
  endtask

  task automatic test_pend_init();
    bit ok;
    int lat;
    apply_reset();
    bus.init_end = 1'b0;
    pulse_frame();
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 0) begin
      failures++; $display("FAIL pend_gated got=%0d exp=0", q_addr.size());
    end
    @(negedge clk);
    bus.init_end = 1'b1;
    lat = 0;
    while (q_addr.size() == 0 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat < 1 || lat > 2) begin
      failures++; $display("FAIL pend_latency got=%0d exp=1..2", lat);
    end
    wait_done(1, 400, ok);
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'd1000 || done_cnt != 1) begin
      failures++; $display("FAIL pend_single_frame got=%0d cmds %0d dones exp=4 cmds 1 done",
                           q_addr.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] exp_a;
    apply_reset();
    bus.init_end = 1'b1;
    pulse_frame();
    wait_rd(2, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_start_timeout got=%0d exp=2", q_addr.size());
    end
    pulse_frame();
    pulse_frame();
    wait_done(2, 600, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_done_timeout got=%0d exp=2", done_cnt);
    end
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 8) begin
      failures++; $display("FAIL b2b_cmd_count got=%0d exp=8", q_addr.size());
    end
    for (int i = 0; i < 8; i++) begin
      exp_a = 32'd1000 + 32'(i);
      checks++;
      if (q_addr.size() <= i || q_addr[i] !== exp_a) begin
        failures++; $display("FAIL b2b_addr%0d got=%0d exp=%0d", i,
                             (q_addr.size() > i) ? q_addr[i] : 32'hFFFF_FFFF, exp_a);
      end
    end
    checks++;
    if (done_cnt != 2) begin
      failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt);
    end
    checks++;
    if (bus.frame_idx !== 3'd2) begin
      failures++; $display("FAIL b2b_frame_idx got=%0d exp=2", bus.frame_idx);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    pulse_frame();
    wait_done(1, 400, ok);
    repeat (3) @(negedge clk);
    clear_log();
    pulse_frame();
    wait_rd(2, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mid_start_timeout got=%0d exp=2", q_addr.size());
    end
    pulse_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_addr !== 32'd1000) begin
      failures++; $display("FAIL mid_rd_addr got=%0d exp=1000", bus.rd_addr);
    end
    checks++;
    if (bus.frame_idx !== 3'd0) begin
      failures++; $display("FAIL mid_frame_idx got=%0d exp=0", bus.frame_idx);
    end
    checks++;
    if (bus.rd_en !== 1'b0 || bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL mid_pulses got=%b%b exp=00", bus.rd_en, bus.frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 0) begin
      failures++; $display("FAIL mid_pend_cleared got=%0d exp=0", q_addr.size());
    end
    pulse_frame();
    wait_rd(1, 100, ok);
    checks++;
    if (!ok || q_addr[0] !== 32'd1000) begin
      failures++; $display("FAIL mid_restart_addr got=%0d exp=1000",
                           (q_addr.size() > 0) ? q_addr[0] : 32'hFFFF_FFFF);
    end
    wait_done(1, 400, ok);
  endtask

`ifdef RD_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    apply_reset();
    ign_cnt = 1;
    pulse_frame();
    wait_rd(2, 100, ok);
    checks++;
    if (!ok || (q_cyc[1] - q_cyc[0]) != 20) begin
      failures++; $display("FAIL to_reissue_gap got=%0d exp=20",
                           (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : -1);
    end
    checks++;
    if (q_addr.size() < 2 || q_addr[0] !== 32'd1000 || q_addr[1] !== 32'd1000) begin
      failures++; $display("FAIL to_reissue_addr got=%0d exp=1000",
                           (q_addr.size() > 1) ? q_addr[1] : 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.rd_err !== 1'b1) begin
      failures++; $display("FAIL to_rd_err_set got=%b exp=1", bus.rd_err);
    end
    wait_done(1, 400, ok);
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (q_addr.size() != 5 || q_addr[4] !== 32'd1003) begin
      failures++; $display("FAIL to_frame_complete got=%0d cmds exp=5", q_addr.size());
    end
    checks++;
    if (bus.rd_err !== 1'b1) begin
      failures++; $display("FAIL to_rd_err_sticky got=%b exp=1", bus.rd_err);
    end
    checks++;
    if (bus.frame_idx !== 3'd1) begin
      failures++; $display("FAIL to_frame_idx got=%0d exp=1", bus.frame_idx);
    end
  endtask
`endif

  initial begin
    bus.frame    = 1'b0;
    bus.init_end = 1'b1;
    test_reset();
    test_single_frame();
    test_wrap();
    test_pend_init();
    test_back_to_back();
    test_reset_mid();
`ifdef RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_rd_ctrl.md
Name: data_rd_ctrl

Overview:
Read-side counterpart of the SD-card frame write controller. On a frame request it issues one single-sector read command per sector of the frame to the SD read module. Each command is an rd_en pulse plus rd_addr. The block paces commands on the read module's rd_busy and walks a ring of frame slots in card address space. It sits between the SD read module (sd_read) and the downstream frame consumer.

Parameters:
BASE_ADDR, 32'd1000, first sector of frame slot 0
SECT_PER_FRAME, 4, sectors per frame (>=1)
FRAME_NUM, 8, frame slots in the ring (>=1)
TIMEOUT_CYC, 1000, cycles allowed from rd_en to rd_busy rising (only with RD_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset, asynchronous, active-low
init_end  in  1  SD card initialisation complete, level
frame  in  1  frame read request, level; its rising edge = one request
rd_busy  in  1  SD read module busy, high while a sector read is in progress
rd_en  out  1  sector read command, one-cycle pulse
rd_addr  out  32  sector address, valid while rd_en=1 and held until the next command
frame_done  out  1  one-cycle pulse after the last sector of a frame completes
frame_idx  out  log2(FRAME_NUM) (min 1)  slot currently or last read
rd_err  out  1  sticky timeout flag; constant 0 without RD_TIMEOUT_EN

Behaviour:
- Reset values: rd_en=0, rd_addr=BASE_ADDR, frame_done=0, frame_idx=0, rd_err=0; FSM in IDLE; sect_cnt=0; pend=0; frame_d1=0; busy_d1=0.
- Edge detection: frame_d1 and busy_d1 are registered copies. req = frame & ~frame_d1. busy_rise / busy_fall use busy_d1 the same way.
- Addressing: rd_addr = BASE_ADDR + frame_idx*SECT_PER_FRAME + sect_cnt, computed in 32 bits, modulo 2^32.
- FSM:
  - IDLE: leave when (req | pend) & init_end & ~rd_busy → REQ; clear pend. If req arrives while init_end=0, set pend.
  - REQ: rd_en=1 for exactly one cycle with rd_addr valid → WAIT_H.
  - WAIT_H: stay until busy_rise → WAIT_L. If rd_busy is already high when entering, it is treated as the rise on the next sampled edge; no command is lost.
  - WAIT_L: stay until busy_fall → NEXT.
  - NEXT (1 cycle):
    - If sect_cnt == SECT_PER_FRAME-1: sect_cnt←0; frame_done=1 in this cycle; frame_idx advances (wraps FRAME_NUM-1→0); → IDLE.
    - Else: sect_cnt+1 → REQ.
- Command rate: minimum spacing between rd_en pulses is 4 cycles (REQ, WAIT_H≥1, WAIT_L≥1, NEXT).
- frame_idx advances in NEXT of the last sector. During a frame it shows the slot being read.
- A req outside IDLE sets pend. The pend register is one deep; further reqs while pend=1 are dropped. A pending request starts from IDLE on the cycle after frame_done.
- A req in the same cycle as frame_done is captured as pend.
- init_end falling mid-frame: the current frame completes; only new starts are gated.
- Reset asserted mid-operation: everything returns to reset values immediately, including frame_idx=0 and pend=0.

Optional Feature:
RD_TIMEOUT_EN
- Defined: a timeout counter runs in WAIT_H. If it reaches TIMEOUT_CYC-1 without busy_rise, the FSM returns to REQ and reissues the same rd_addr; sect_cnt is unchanged. rd_err is set and stays set until reset.
- Not defined: WAIT_H waits indefinitely; no counter is synthesized; rd_err is tied 0.

Decomposition:
- Package data_rd_pkg: FSM state encoding (IDLE, REQ, WAIT_H, WAIT_L, NEXT) and the address width constant ADDR_W=32.
- Sub-module edge_det: a registered rising/falling edge detector, instantiated for frame and rd_busy. It is also reusable by the write controller.

Test Plan:
- Reset, init_end=1, one frame rise, model busy high 3 cycles after each rd_en for 10 cycles → 4 rd_en pulses at addr 1000, 1001, 1002, 1003; one frame_done; frame_idx 0→1.
- 9 consecutive frames → slots 0..7 then wrap; 9th frame reads 1000..1003; frame_idx=0 after the 8th frame_done.
- frame rise while init_end=0, init_end rises 50 cycles later → first rd_en 2 cycles after init_end is seen; no second request.
- Two frame rises during an active frame → exactly one extra frame follows, second frame at 1004..1007; the third request is dropped.
- Reset pulsed mid-frame after the 2nd rd_en → outputs return to reset values; the next request restarts at addr 1000.
- RD_TIMEOUT_EN defined, TIMEOUT_CYC=20, model ignores the first command → rd_en reissued at the same address 20 cycles later; rd_err=1 and stays set; the frame still completes.
